// File: rtl/i2c_cmd_arbiter.sv
// Two-port round-robin command arbiter in front of the shared I2C write controller.
// Handles NACK retry, stalled-transfer timeout and per-port done/err pulses.
module i2c_cmd_arbiter #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int         MAX_RETRY  = 2,
  parameter int         TIMEOUT    = 64
) (
  input  logic        clk_i2c,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  input  logic        i2c_end,
  input  logic [2:0]  i2c_ack,
  output logic        busy,
  output logic [1:0]  gnt
);

  // state    | meaning
  // IDLE     | no owner; arbitrate eligible requests
  // WAIT_END | GO high, waiting for END or timeout
  // RELEASE  | GO low, waiting for END to fall
  // CHECK    | decide done / retry / err
  typedef enum logic [1:0] {IDLE, WAIT_END, RELEASE, CHECK} state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  state_t      r_state;
  logic        r_ptr;
  logic [1:0]  r_retry;
  logic [7:0]  r_timer;
  logic [2:0]  r_ack;
  logic        r_tmo;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_pick1;
  logic        w_tmo_hit;
  logic        w_retry_ok;
  logic [7:0]  w_timer_inc;

  // A port whose pulse is high is masked so it may drop req on that edge.
  assign w_elig0     = req0 & ~done0 & ~err0;
  assign w_elig1     = req1 & ~done1 & ~err1;
  assign w_pick1     = w_elig1 & (~w_elig0 | ~r_ptr);
  assign w_tmo_hit   = (r_timer == TMO_LAST);
  assign w_retry_ok  = (r_retry < RETRY_MAX);
  assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;
  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b1;
      r_retry  <= 2'd0;
      r_timer  <= 8'd0;
      r_ack    <= 3'd0;
      r_tmo    <= 1'b0;
      i2c_data <= 24'd0;
      i2c_go   <= 1'b0;
      gnt      <= 2'b00;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((w_elig0 | w_elig1) && !i2c_end) begin
            i2c_data <= {SLAVE_ADDR, 1'b0, (w_pick1 ? cmd1 : cmd0)};
            i2c_go   <= 1'b1;
            r_retry  <= 2'd0;
            r_timer  <= 8'd0;
            r_tmo    <= 1'b0;
            gnt      <= w_pick1 ? 2'b10 : 2'b01;
            r_ptr    <= w_pick1;
            r_state  <= WAIT_END;
          end
        end
        WAIT_END: begin
          if (i2c_end) begin
            r_ack   <= i2c_ack;
            i2c_go  <= 1'b0;
            r_timer <= 8'd0;
            r_state <= RELEASE;
          end else if (w_tmo_hit) begin
            i2c_go  <= 1'b0;
            r_tmo   <= 1'b1;
            r_timer <= 8'd0;
            r_state <= RELEASE;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        RELEASE: begin
          // END stuck high after GO drops is treated as a stalled transfer too.
          if (!i2c_end) begin
            r_state <= CHECK;
          end else if (w_tmo_hit) begin
            r_tmo   <= 1'b1;
            r_state <= CHECK;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        CHECK: begin
          if (!r_tmo && (r_ack == 3'd0)) begin
            done0   <= gnt[0];
            done1   <= gnt[1];
            gnt     <= 2'b00;
            r_state <= IDLE;
          end else if (!r_tmo && w_retry_ok) begin
            r_retry <= r_retry + 2'd1;
            i2c_go  <= 1'b1;
            r_timer <= 8'd0;
            r_state <= WAIT_END;
          end else begin
            err0    <= gnt[0];
            err1    <= gnt[1];
            gnt     <= 2'b00;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized self-checking bench for i2c_cmd_arbiter with a behavioural I2C
// controller responder and a transaction-level reference model.
module tb_i2c_cmd_arbiter;

  logic        clk_i2c = 1'b0;
  logic        reset_n;
  logic [1:0]  req;
  logic [15:0] cmd0, cmd1;
  logic        done0, done1, err0, err1;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic [2:0]  i2c_ack;
  logic        busy;
  logic [1:0]  gnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gcnt = 0;
  bit stall = 0;
  bit go_prev = 0;
  int tb_ptr = 1;

  logic [2:0]  ackq[$];
  logic [23:0] go_q[$];
  logic [23:0] exp_data[$];
  logic [1:0]  gnt_q[$];
  logic [1:0]  exp_gnt[$];
  int          tgo_q[$];
  int          cnt_done[2];
  int          cnt_err[2];
  int          t_pulse[2];
  int          exp_kind[2];
  int          got_kind[2];

  i2c_cmd_arbiter dut (
    .clk_i2c (clk_i2c),
    .reset_n (reset_n),
    .req0    (req[0]),
    .req1    (req[1]),
    .cmd0    (cmd0),
    .cmd1    (cmd1),
    .done0   (done0),
    .done1   (done1),
    .err0    (err0),
    .err1    (err1),
    .i2c_data(i2c_data),
    .i2c_go  (i2c_go),
    .i2c_end (i2c_end),
    .i2c_ack (i2c_ack),
    .busy    (busy),
    .gnt     (gnt)
  );

  always #5 clk_i2c = ~clk_i2c;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Controller responder: END rises after GO has been high 33 cycles, falls after GO drops.
  initial begin
    i2c_end = 1'b0;
    i2c_ack = 3'b000;
    forever begin
      @(negedge clk_i2c);
      if (!i2c_go) begin
        gcnt    = 0;
        i2c_end = 1'b0;
      end else begin
        gcnt++;
        if (!stall && gcnt == 33) begin
          i2c_end = 1'b1;
          if (ackq.size() > 0) i2c_ack = ackq.pop_front();
          else i2c_ack = 3'b000;
        end
      end
    end
  end

  // Monitor: log every GO rise and every pulse.
  initial begin
    forever begin
      @(negedge clk_i2c);
      cyc++;
      if (i2c_go && !go_prev) begin
        go_q.push_back(i2c_data);
        gnt_q.push_back(gnt);
        tgo_q.push_back(cyc);
        check_val("go_rise_end_low", 32'(i2c_end), 32'd0);
      end
      go_prev = i2c_go;
      if (done0) begin cnt_done[0]++; t_pulse[0] = cyc; end
      if (done1) begin cnt_done[1]++; t_pulse[1] = cyc; end
      if (err0)  begin cnt_err[0]++;  t_pulse[0] = cyc; end
      if (err1)  begin cnt_err[1]++;  t_pulse[1] = cyc; end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    go_q.delete(); gnt_q.delete(); tgo_q.delete();
    exp_data.delete(); exp_gnt.delete();
    for (int p = 0; p < 2; p++) begin
      cnt_done[p] = 0; cnt_err[p] = 0; t_pulse[p] = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 2'b00;
    stall   = 1'b0;
    ackq.delete();
    repeat (3) @(negedge clk_i2c);
    reset_n = 1'b1;
    tb_ptr  = 1;
    clear_logs();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_go"},    32'(i2c_go),   32'd0);
    check_val({pfx, "_data"},  32'(i2c_data), 32'd0);
    check_val({pfx, "_done0"}, 32'(done0),    32'd0);
    check_val({pfx, "_done1"}, 32'(done1),    32'd0);
    check_val({pfx, "_err0"},  32'(err0),     32'd0);
    check_val({pfx, "_err1"},  32'(err1),     32'd0);
    check_val({pfx, "_busy"},  32'(busy),     32'd0);
    check_val({pfx, "_gnt"},   32'(gnt),      32'd0);
  endtask

  // kind: 1 = done, 2 = err, 0 = nothing within the cycle budget
  task automatic wait_pulse(input int p, output int kind);
    kind = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i2c);
      if ((p == 0) ? done0 : done1) begin kind = 1; break; end
      if ((p == 0) ? err0 : err1) begin kind = 2; break; end
    end
  endtask

  // Reference model for one served command: up to three attempts, stop at first clean ACK.
  task automatic plan_port(input int p, input logic [15:0] c,
                           input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    logic [2:0] a[3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    exp_kind[p] = 2;
    for (int i = 0; i < 3; i++) begin
      ackq.push_back(a[i]);
      exp_data.push_back({7'h1A, 1'b0, c});
      exp_gnt.push_back((p == 0) ? 2'b01 : 2'b10);
      if (a[i] == 3'b000) begin
        exp_kind[p] = 1;
        break;
      end
    end
    tb_ptr = p;
  endtask

  function automatic logic [2:0] rnd_ack();
    if ($urandom_range(0, 2) == 0) return 3'($urandom_range(1, 7));
    return 3'b000;
  endfunction

  task automatic run_and_check(input logic [1:0] m);
    @(negedge clk_i2c);
    got_kind[0] = 0;
    got_kind[1] = 0;
    req = m;
    fork
      begin
        if (m[0]) begin wait_pulse(0, got_kind[0]); req[0] = 1'b0; end
      end
      begin
        if (m[1]) begin wait_pulse(1, got_kind[1]); req[1] = 1'b0; end
      end
    join
    repeat (4) @(negedge clk_i2c);
    for (int p = 0; p < 2; p++) begin
      if (m[p]) check_val((p == 0) ? "kind0" : "kind1", got_kind[p], exp_kind[p]);
      check_val((p == 0) ? "pulses0" : "pulses1", cnt_done[p] + cnt_err[p], 32'(m[p]));
    end
    check_val("go_count", go_q.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < go_q.size(); i++) begin
      check_val("go_data", 32'(go_q[i]), 32'(exp_data[i]));
      check_val("go_gnt", 32'(gnt_q[i]), 32'(exp_gnt[i]));
    end
    check_val("busy_after", 32'(busy), 32'd0);
    check_val("gnt_after", 32'(gnt), 32'd0);
  endtask

  initial begin
    int lat, hi, k0a, k0b, k1, first;
    logic [1:0] m;
    reset_n = 1'b1;
    req = 2'b00;
    cmd0 = 16'h0000;
    cmd1 = 16'h0000;
    #1 reset_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk_i2c);
    reset_n = 1'b1;
    tb_ptr = 1;
    clear_logs();

    // Single request with clean ACK
    cmd0 = {7'h02, 9'h079};
    plan_port(0, cmd0, 3'b000, 3'b000, 3'b000);
    run_and_check(2'b01);
    check_val("single_data", (go_q.size() > 0) ? 32'(go_q[0]) : 32'd0, 32'h340479);
    lat = (tgo_q.size() > 0) ? (t_pulse[0] - tgo_q[0]) : 0;
    check_val("done_latency", 32'(lat >= 33 && lat <= 38), 32'd1);
    clear_logs();

    // Contention from reset: 0 first, port 0 re-requests, order 0,1,0
    do_reset();
    cmd0 = 16'($urandom);
    cmd1 = 16'($urandom);
    ackq.push_back(3'b000); ackq.push_back(3'b000); ackq.push_back(3'b000);
    @(negedge clk_i2c);
    req = 2'b11;
    fork
      begin wait_pulse(0, k0a); wait_pulse(0, k0b); req[0] = 1'b0; end
      begin wait_pulse(1, k1); req[1] = 1'b0; end
    join
    repeat (4) @(negedge clk_i2c);
    check_val("rr_count", gnt_q.size(), 3);
    check_val("rr_first",  (gnt_q.size() > 0) ? 32'(gnt_q[0]) : 32'd0, 32'd1);
    check_val("rr_second", (gnt_q.size() > 1) ? 32'(gnt_q[1]) : 32'd0, 32'd2);
    check_val("rr_third",  (gnt_q.size() > 2) ? 32'(gnt_q[2]) : 32'd0, 32'd1);
    check_val("rr_kind0a", k0a, 1);
    check_val("rr_kind0b", k0b, 1);
    check_val("rr_kind1", k1, 1);
    tb_ptr = 0;
    clear_logs();

    // Single NACK then clean
    cmd0 = 16'($urandom);
    plan_port(0, cmd0, 3'b010, 3'b000, 3'b000);
    run_and_check(2'b01);
    clear_logs();

    // Persistent NACK on port 1
    cmd1 = 16'($urandom);
    plan_port(1, cmd1, 3'b001, 3'b001, 3'b001);
    run_and_check(2'b10);
    clear_logs();

    // Stalled controller
    stall = 1'b1;
    cmd0 = 16'($urandom);
    @(negedge clk_i2c);
    req = 2'b01;
    hi = 0;
    fork
      begin wait_pulse(0, k0a); req[0] = 1'b0; end
      begin
        for (int i = 0; i < 20 && !i2c_go; i++) @(negedge clk_i2c);
        while (i2c_go && hi < 200) begin hi++; @(negedge clk_i2c); end
      end
    join
    repeat (4) @(negedge clk_i2c);
    check_val("stall_go_width", hi, 64);
    check_val("stall_kind", k0a, 2);
    check_val("stall_attempts", go_q.size(), 1);
    stall = 1'b0;
    tb_ptr = 0;
    clear_logs();
    plan_port(0, cmd0, 3'b000, 3'b000, 3'b000);
    run_and_check(2'b01);
    clear_logs();

    // Reset mid-transfer, port 1 pending
    cmd0 = 16'($urandom);
    cmd1 = 16'($urandom);
    @(negedge clk_i2c);
    req = 2'b01;
    for (int i = 0; i < 20 && !i2c_go; i++) @(negedge clk_i2c);
    repeat (15) @(negedge clk_i2c);
    #2 reset_n = 1'b0;
    req = 2'b10;
    #1 check_reset_outputs("midrst");
    ackq.delete();
    clear_logs();
    repeat (2) @(negedge clk_i2c);
    reset_n = 1'b1;
    tb_ptr = 1;
    plan_port(1, cmd1, 3'b000, 3'b000, 3'b000);
    run_and_check(2'b10);
    clear_logs();

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      m = 2'($urandom_range(1, 3));
      cmd0 = 16'($urandom);
      cmd1 = 16'($urandom);
      if (m == 2'b11) begin
        first = (tb_ptr == 1) ? 0 : 1;
        plan_port(first, (first == 1) ? cmd1 : cmd0, rnd_ack(), rnd_ack(), rnd_ack());
        plan_port(1 - first, (first == 1) ? cmd0 : cmd1, rnd_ack(), rnd_ack(), rnd_ack());
      end else begin
        first = m[1] ? 1 : 0;
        plan_port(first, (first == 1) ? cmd1 : cmd0, rnd_ack(), rnd_ack(), rnd_ack());
      end
      run_and_check(m);
      clear_logs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Two-port command arbiter and sequencer in front of the shared I2C write controller (24-bit {addr, reg, data} word, GO/END/ACK handshake) on the clk_i2c domain. It serves the codec boot-configuration sequencer and a runtime control requester, such as a volume or mute update, without collisions. It also handles retry on NACK, timeout on a stalled transfer, and per-port completion and error reporting.

## Interface
- SLAVE_ADDR, 7'h1A: 7-bit codec address; the write bit is always 0.
- MAX_RETRY, 2: re-sends allowed after a NACK.
- TIMEOUT, 64: clk_i2c cycles allowed for END to rise, or to fall after GO drops.
- clk_i2c  in  1  controller clock, about 10 kHz.
- reset_n  in  1  reset; asynchronous, active-low.
- req0, req1  in  1  request, held high until done/err for that port.
- cmd0, cmd1  in  16  {reg[6:0], data[8:0]}; must be stable while req is high.
- done0, done1  out  1  one-cycle pulse: command written and all three ACK bits were 0.
- err0, err1  out  1  one-cycle pulse: command abandoned after retries exhausted or timeout.
- i2c_data  out  24  {SLAVE_ADDR, 1'b0, reg, data} to the controller.
- i2c_go  out  1  GO to the controller.
- i2c_end  in  1  END from the controller.
- i2c_ack  in  3  ACK from the controller; 1 in any bit means NACK.
- busy  out  1  high in every state except IDLE.
- gnt  out  2  one-hot owner of the current transaction; 0 in IDLE.

## Operation
- States: IDLE, WAIT_END, RELEASE, CHECK.
- **IDLE**
  - Eligible port n: reqn=1 and donen=0 and errn=0. Ports whose pulse is currently high are masked, so a requester can drop req on the edge it sees the pulse.
  - One port eligible: grant it.
  - Both eligible: round-robin. The port not granted last wins. The last-grant pointer resets to 1, so port 0 wins first.
  - On the grant edge:
    - latch cmd into i2c_data;
    - i2c_go<=1;
    - retry_cnt<=0;
    - timer<=0;
    - gnt set;
    - go to WAIT_END.
- **WAIT_END**: timer increments each cycle.
  - i2c_end=1: capture i2c_ack into ack_r, i2c_go<=0, timer<=0, go to RELEASE.
  - timer reaches TIMEOUT-1 first: i2c_go<=0, set tmo flag, go to RELEASE.
- **RELEASE**: wait for i2c_end=0, or TIMEOUT cycles, then go to CHECK. This guarantees the controller has re-armed before any new GO.
- **CHECK**
  - tmo set: errn pulse, go to IDLE. No retry.
  - ack_r==0: donen pulse, go to IDLE.
  - ack_r!=0 and retry_cnt<MAX_RETRY: retry_cnt+1, i2c_go<=1, timer<=0, go to WAIT_END. i2c_data is unchanged.
  - Otherwise: errn pulse, go to IDLE.
- done/err pulses are registered and high during the first IDLE cycle after CHECK. gnt clears in that same cycle.
- i2c_data holds its last value while idle.
- Total attempts per command ≤ MAX_RETRY+1.
- retry_cnt is 2 bits wide. timer is 8 bits wide and saturates.

## Timing
- Reset (async): state IDLE.
  - i2c_go=0, i2c_data=0.
  - done0/1=0, err0/1=0.
  - busy=0, gnt=0, pointer=1.
- Reset mid-transfer abandons the command silently. No done/err is issued, and GO drops immediately.
- Grant latency: IDLE sees req at edge E, so i2c_go=1 and i2c_data are valid after E.
- Per attempt with the team I2C controller (END rises 33 cycles after GO): GO-high to capture about 33 cycles, then 1 cycle in RELEASE and 1 in CHECK.
- Done pulse follows request acceptance by about 36 cycles.
- Back-to-back transactions: minimum 1 IDLE cycle between GO-low and the next GO-high. i2c_go never rises while i2c_end=1.
- req dropped mid-transaction: the transaction still completes and still pulses done/err.
- cmd changes mid-transaction: ignored; the value latched at grant is used.

## Test plan
- Single request: req0=1, cmd0={7'h02, 9'h079}, ACK=000.
  - i2c_data=24'h340479.
  - One GO pulse.
  - done0 pulse at about 36 cycles.
  - busy low afterwards.
- Contention: req0 and req1 high in the same cycle.
  - Port 0 is served first, then port 1.
  - Port 0 re-requests immediately: order is 0,1,0. Port 1 is never starved.
- Single NACK: ACK=010 on the first attempt, 000 on the second.
  - Exactly 2 GO pulses carrying the same i2c_data.
  - done0; no err0.
- Persistent NACK with MAX_RETRY=2: ACK=001 on every attempt.
  - Exactly 3 GO pulses, then one err1 pulse.
  - done1 never asserts.
- Stalled controller: i2c_end held at 0.
  - i2c_go drops after 64 cycles.
  - err0 pulse with no retry.
  - The next request is served normally.
- Reset mid-transfer: reset_n=0 at cycle 15 of an attempt.
  - All outputs at reset values.
  - No done/err pulse.
  - After release, a pending req1 is granted first: the pointer is 1, so the round-robin rule gives port 0 first only when both ports request.
